alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//   Sequential, handshaked ALU for the RISC-V core: the single-cycle ops AND/OR/ADD/SUB
//   plus XOR/SLT/SLTU and iterative RV M-extension multiply/divide.
//   Sits in EX. The pipeline stalls on IN_READY=0 and holds the result in EX/MEM until OUT_READY.
// PARAMETERS
//   WORDSIZE  64  operand/result width; any value >=8; counter width = $clog2(WORDSIZE)+1
//   M_EN      1   1 = implement MUL/DIV codes; 0 = M codes produce R=0 at 1-cycle latency
// PORTS
//   CLK        in   1         clock, rising edge
//   RST_N      in   1         asynchronous reset, active low
//   IN_VALID   in   1         A, B, CTL valid this cycle
//   IN_READY   out  1         block can accept; transfer when IN_VALID & IN_READY
//   A, B       in   WORDSIZE  operands
//   CTL        in   4         operation code (see BEHAVIOUR)
//   OUT_VALID  out  1         R, Z valid; held until OUT_READY
//   OUT_READY  in   1         consumer takes result when OUT_VALID & OUT_READY
//   R          out  WORDSIZE  registered result
//   Z          out  1         registered ~|R
// BEHAVIOUR
//   CTL: AND 0000, OR 0001, ADD 0010, XOR 0011, SLTU 0100, SUB 0110, SLT 0111,
//        MUL 1000 (low half), MULHU 1001 (high half, unsigned), DIV 1100, DIVU 1101,
//        REM 1110, REMU 1111. Codes 0101, 1010, 1011 give R=0, Z=1 at 1-cycle latency.
//   Reset (RST_N low, any state, mid-op included): state=IDLE, IN_READY=1, OUT_VALID=0,
//     R=0, Z=1, counter=0. Any in-flight op is discarded.
//   FSM: IDLE -> DONE (1-cycle op) | IDLE -> CALC -> FIX -> DONE (M op);
//     DONE -> IDLE when OUT_READY.
//   IN_READY = (state==IDLE). Operands and CTL are latched on accept; later input changes are ignored.
//   Latency, accept edge to OUT_VALID=1: 1-cycle ops = 1 clk; M ops = WORDSIZE+2 clk,
//     fixed regardless of data. Throughput is at most 1 op per 2 clks.
//   OUT_VALID=1 only in DONE. R/Z are stable while OUT_VALID & !OUT_READY.
//   Arithmetic: ADD/SUB wrap modulo 2^WORDSIZE. SLT is signed, SLTU unsigned; result is 0 or 1.
//   MUL/MULHU: shift-add, one bit per CALC cycle, 2*WORDSIZE-bit product; MUL returns bits
//     [W-1:0] and MULHU bits [2W-1:W].
//   DIV/REM: restoring, one quotient bit per CALC cycle, on magnitudes.
//     Signed ops record operand signs on accept; FIX negates the quotient when signs differ
//     and gives the remainder the dividend's sign.
//   Special cases, detected at accept, result forced in FIX (latency unchanged):
//     B==0: quotient = all ones, remainder = A.
//     DIV/REM with A = most-negative and B = -1: quotient = A, remainder = 0.
//   Counter runs WORDSIZE-1 down to 0 in CALC; CALC exits to FIX when it reaches 0.
//   Simultaneous IN_VALID in DONE is ignored (IN_READY=0) and must be held by the source.
// STRUCTURE
//   Shared package alu_pkg: localparams for the CTL codes, the state encoding
//     (IDLE, CALC, FIX, DONE) and the is_mdu(ctl) classification function.
//   One sub-module, alu_mdu_core: iterative shift-add/restoring datapath with
//     start/busy/done, sign fix-up and the special-case override.
//     The top holds the FSM, handshake, single-cycle ops and the R/Z registers.
// TESTING
//   1. WORDSIZE=64: ADD A=FFFF_FFFF_FFFF_FFFF, B=1 -> R=0, Z=1, OUT_VALID 1 clk after accept.
//   2. SUB 5-7 -> R=FFFF_FFFF_FFFF_FFFE; SLT A=-1, B=1 -> 1; SLTU same operands -> 0.
//   3. MUL A=3, B=-2 -> R=FFFF_FFFF_FFFF_FFFA; MULHU A=B=FFFF_FFFF_FFFF_FFFF -> R=FFFF_FFFF_FFFF_FFFE;
//      both at 66-clk latency, IN_READY=0 throughout.
//   4. DIV -7/2 -> R=-3; REM -7/2 -> R=-1; DIVU 7/0 -> R=all ones; REMU 7/0 -> 7;
//      DIV 8000_0000_0000_0000 / -1 -> R=8000_0000_0000_0000.
//   5. Backpressure: OUT_READY=0 for 5 clks after a result -> R, Z, OUT_VALID stable; IN_READY=0;
//      operands changed meanwhile are ignored.
//   6. RST_N asserted at CALC cycle 20 -> OUT_VALID=0, IN_READY=1 asynchronously;
//      the next ADD 2+2 returns 4 at 1-cycle latency. Repeat case 3 with WORDSIZE=8: latency 10.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared operation codes, FSM encoding and op classification for alu_seq
package alu_pkg;

    localparam logic [3:0] CTL_AND   = 4'b0000;
    localparam logic [3:0] CTL_OR    = 4'b0001;
    localparam logic [3:0] CTL_ADD   = 4'b0010;
    localparam logic [3:0] CTL_XOR   = 4'b0011;
    localparam logic [3:0] CTL_SLTU  = 4'b0100;
    localparam logic [3:0] CTL_SUB   = 4'b0110;
    localparam logic [3:0] CTL_SLT   = 4'b0111;
    localparam logic [3:0] CTL_MUL   = 4'b1000;
    localparam logic [3:0] CTL_MULHU = 4'b1001;
    localparam logic [3:0] CTL_DIV   = 4'b1100;
    localparam logic [3:0] CTL_DIVU  = 4'b1101;
    localparam logic [3:0] CTL_REM   = 4'b1110;
    localparam logic [3:0] CTL_REMU  = 4'b1111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // 1010 and 1011 have bit 3 set but are not M-extension codes.
    function automatic logic is_mdu(input logic [3:0] ctl);
        return ctl[3] && (ctl[2:1] != 2'b01);
    endfunction

endpackage

// File: rtl/alu_mdu_core.sv
// rtl/alu_mdu_core.sv - iterative shift-add multiplier / restoring divider with sign fix-up
module alu_mdu_core #(
    parameter int WORDSIZE = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [2:0]          op,
    input  logic [WORDSIZE-1:0] a,
    input  logic [WORDSIZE-1:0] b,
    output logic                last,
    output logic [WORDSIZE-1:0] result
);
    import alu_pkg::*;

    localparam int CW = $clog2(WORDSIZE) + 1;
    localparam logic [WORDSIZE-1:0] MIN_NEG = {1'b1, {(WORDSIZE-1){1'b0}}};

    logic                busy;
    logic [CW-1:0]       cnt;
    logic [WORDSIZE-1:0] acc;
    logic [WORDSIZE-1:0] lo;
    logic [WORDSIZE-1:0] opd;
    logic                is_div, want_rem, want_hi, neg_q, neg_r, div0, ovf;

    logic                signed_div;
    logic [WORDSIZE:0]   mul_sum;
    logic [WORDSIZE:0]   rem_s;
    logic [WORDSIZE:0]   diff;
    logic [WORDSIZE-1:0] q_fix, r_fix;

    function automatic logic [WORDSIZE-1:0] mag(input logic [WORDSIZE-1:0] x, input logic s);
        return (s && x[WORDSIZE-1]) ? -x : x;
    endfunction

    // op[2]=divide, op[1]=remainder, op[0]=unsigned (divide) or high half (multiply)
    assign signed_div = op[2] & ~op[0];

    assign mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, opd} : '0);
    assign rem_s   = {acc, lo[WORDSIZE-1]};
    assign diff    = rem_s - {1'b0, opd};
    assign last    = busy && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            lo       <= '0;
            opd      <= '0;
            is_div   <= 1'b0;
            want_rem <= 1'b0;
            want_hi  <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div0     <= 1'b0;
            ovf      <= 1'b0;
        end else if (start) begin
            busy     <= 1'b1;
            cnt      <= CW'(WORDSIZE - 1);
            acc      <= '0;
            is_div   <= op[2];
            want_rem <= op[1];
            want_hi  <= op[0];
            if (op[2]) begin
                lo    <= mag(a, signed_div);
                opd   <= mag(b, signed_div);
                neg_q <= signed_div & (a[WORDSIZE-1] ^ b[WORDSIZE-1]);
                neg_r <= signed_div & a[WORDSIZE-1];
                div0  <= (b == '0);
                ovf   <= signed_div && (a == MIN_NEG) && (b == '1);
            end else begin
                lo    <= b;
                opd   <= a;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
                div0  <= 1'b0;
                ovf   <= 1'b0;
            end
        end else if (busy) begin
            if (is_div) begin
                acc <= diff[WORDSIZE] ? rem_s[WORDSIZE-1:0] : diff[WORDSIZE-1:0];
                lo  <= {lo[WORDSIZE-2:0], ~diff[WORDSIZE]};
            end else begin
                acc <= mul_sum[WORDSIZE:1];
                lo  <= {mul_sum[0], lo[WORDSIZE-1:1]};
            end
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // A zero divisor already leaves |A| as the remainder, so only the quotient needs forcing there.
    always_comb begin
        q_fix = neg_q ? -lo : lo;
        r_fix = neg_r ? -acc : acc;
        if (div0) begin
            q_fix = '1;
        end
        if (ovf) begin
            q_fix = MIN_NEG;
            r_fix = '0;
        end
        if (is_div) begin
            result = want_rem ? r_fix : q_fix;
        end else begin
            result = want_hi ? acc : lo;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked EX-stage ALU: single-cycle logic/arith plus iterative MUL/DIV
module alu_seq #(
    parameter int WORDSIZE = 64,
    parameter int M_EN     = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORDSIZE-1:0] a,
    input  logic [WORDSIZE-1:0] b,
    input  logic [3:0]          ctl,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORDSIZE-1:0] r,
    output logic                z
);
    import alu_pkg::*;

    logic [1:0]          state;
    logic [WORDSIZE-1:0] alu_res;
    logic [WORDSIZE-1:0] mdu_res;
    logic                mdu_last;
    logic                mdu_go;
    logic                accept;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;
    assign mdu_go    = (M_EN != 0) && is_mdu(ctl);

    // M codes fall to the default here, giving R=0 when the multiplier/divider is disabled.
    always_comb begin
        alu_res = '0;
        case (ctl)
            CTL_AND:  alu_res = a & b;
            CTL_OR:   alu_res = a | b;
            CTL_ADD:  alu_res = a + b;
            CTL_XOR:  alu_res = a ^ b;
            CTL_SLTU: alu_res = {{(WORDSIZE-1){1'b0}}, (a < b)};
            CTL_SUB:  alu_res = a - b;
            CTL_SLT:  alu_res = {{(WORDSIZE-1){1'b0}}, ($signed(a) < $signed(b))};
            default:  alu_res = '0;
        endcase
    end

    alu_mdu_core #(
        .WORDSIZE(WORDSIZE)
    ) u_mdu (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && mdu_go),
        .op     (ctl[2:0]),
        .a      (a),
        .b      (b),
        .last   (mdu_last),
        .result (mdu_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            r     <= '0;
            z     <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (mdu_go) begin
                            state <= S_CALC;
                        end else begin
                            r     <= alu_res;
                            z     <= ~|alu_res;
                            state <= S_DONE;
                        end
                    end
                end
                S_CALC: begin
                    if (mdu_last) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r     <= mdu_res;
                    z     <= ~|mdu_res;
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
